// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty monitor: FSM state encoding and period arithmetic.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        MEASURE,
        DONE
    } monitor_state_t;

    function automatic int unsigned pwm_period(input int unsigned res);
        return 32'd1 << res;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO; head entry is presented on pop_data whenever not empty.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // NOTE: storage has no reset; occupancy is tracked by count, and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pwm_duty_monitor.sv
// Measures PWM high-time per period over a triggered burst and streams samples through a FIFO.
// Optional monotonic-shape checker enabled by defining PWM_DUTY_SHAPE_CHECK_EN.
module pwm_duty_monitor
    import pwm_pkg::*;
#(
    parameter int PWM_RESOLUTION = 16,
    parameter int D              = 8,
    parameter int ALIGN_DELAY    = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trigger_in,
    input  logic [D-1:0]              duration_in,
    input  logic                      waveform_in,
    output logic [PWM_RESOLUTION:0]   sample_data,
    output logic [D-1:0]              sample_index,
    output logic                      sample_last,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      shape_err
);
    localparam int unsigned PERIOD = pwm_period(PWM_RESOLUTION);
    localparam int CW = PWM_RESOLUTION + 1;
    localparam int AW = (ALIGN_DELAY > 1) ? $clog2(ALIGN_DELAY) : 1;
    localparam logic [PWM_RESOLUTION-1:0] PHASE_LAST = PWM_RESOLUTION'(PERIOD - 1);
    localparam logic [AW-1:0] ALIGN_LAST = AW'((ALIGN_DELAY > 0) ? ALIGN_DELAY - 1 : 0);

    typedef struct packed {
        logic [CW-1:0] data;
        logic [D-1:0]  index;
        logic          last;
    } sample_t;

    monitor_state_t            state, state_n;
    logic                      trig_q;
    logic [D-1:0]              dur;
    logic [D-1:0]              idx;
    logic [PWM_RESOLUTION-1:0] phase;
    logic [CW-1:0]             hi_cnt;
    logic [CW-1:0]             hi_now;
    logic [AW-1:0]             align_cnt;
    logic                      overflow_q;
    logic                      rise;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      drop;
    logic                      fifo_full;
    logic                      fifo_empty;
    sample_t                   push_sample;
    sample_t                   head;

    assign rise   = trigger_in && !trig_q;
    assign hi_now = hi_cnt + CW'(waveform_in);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    accept = 1'b1;
                    if (duration_in == '0)    state_n = DONE;
                    else if (ALIGN_DELAY == 0) state_n = MEASURE;
                    else                       state_n = ALIGN;
                end
            end
            ALIGN: begin
                if (align_cnt == ALIGN_LAST) state_n = MEASURE;
            end
            MEASURE: begin
                if (phase == PHASE_LAST) begin
                    push = 1'b1;
                    if (idx == dur - D'(1)) state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q     <= 1'b0;
            dur        <= '0;
            idx        <= '0;
            phase      <= '0;
            hi_cnt     <= '0;
            align_cnt  <= '0;
            overflow_q <= 1'b0;
        end else begin
            trig_q <= trigger_in;
            if (accept) begin
                dur        <= duration_in;
                idx        <= '0;
                phase      <= '0;
                hi_cnt     <= '0;
                align_cnt  <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (state == ALIGN) align_cnt <= align_cnt + AW'(1);
                if (state == MEASURE) begin
                    phase <= phase + PWM_RESOLUTION'(1);
                    if (push) begin
                        hi_cnt <= '0;
                        idx    <= idx + D'(1);
                    end else begin
                        hi_cnt <= hi_now;
                    end
                end
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    assign push_sample.data  = hi_now;
    assign push_sample.index = idx;
    assign push_sample.last  = (idx == dur - D'(1));

    assign pop  = !fifo_empty && sample_ready;
    assign drop = push && fifo_full && !pop;

    sample_fifo #(
        .WIDTH ($bits(sample_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_sample),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sample_data  = head.data;
    assign sample_index = head.index;
    assign sample_last  = head.last;
    assign sample_valid = !fifo_empty;
    assign busy         = (state == ALIGN) || (state == MEASURE);
    assign done         = (state == DONE);
    assign overflow     = overflow_q;

`ifdef PWM_DUTY_SHAPE_CHECK_EN
    // The half is chosen by the earlier sample of each pair, so a peak at idx dur/2 is legal.
    logic [CW-1:0] prev_data;
    logic [D-1:0]  prev_idx;
    logic          violation;
    logic          shape_q;

    always_comb begin
        prev_idx  = idx - D'(1);
        violation = 1'b0;
        if (push && idx != '0) begin
            if (prev_idx < (dur >> 1)) violation = (hi_now < prev_data);
            else                       violation = (hi_now > prev_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_data <= '0;
            shape_q   <= 1'b0;
        end else begin
            if (accept)         shape_q <= 1'b0;
            else if (violation) shape_q <= 1'b1;
            if (push) prev_data <= hi_now;
        end
    end

    assign shape_err = shape_q;
`else
    assign shape_err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_duty_monitor.sv
// Scoreboard bench for pwm_duty_monitor: randomized bursts checked against a period-sum reference model.
module tb_pwm_duty_monitor;
    import pwm_pkg::*;

    localparam int RES   = 4;
    localparam int IW    = 8;
    localparam int A     = 2;
    localparam int DEPTH = 4;
    localparam int P     = 16;
`ifdef PWM_DUTY_SHAPE_CHECK_EN
    localparam bit SHAPE_ON = 1'b1;
`else
    localparam bit SHAPE_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          trigger_in;
    logic [IW-1:0] duration_in;
    logic          waveform_in;
    logic [RES:0]  sample_data;
    logic [IW-1:0] sample_index;
    logic          sample_last;
    logic          sample_valid;
    logic          sample_ready;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          shape_err;

    pwm_duty_monitor #(
        .PWM_RESOLUTION (RES),
        .D              (IW),
        .ALIGN_DELAY    (A),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trigger_in   (trigger_in),
        .duration_in  (duration_in),
        .waveform_in  (waveform_in),
        .sample_data  (sample_data),
        .sample_index (sample_index),
        .sample_last  (sample_last),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .shape_err    (shape_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int index;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   exp_overflow = 1'b0;
    bit   exp_shape = 1'b0;
    int   ready_mode = 0;
    bit   random_bits = 1'b0;
    int   duties[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = 1'b0;
            default: sample_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Monitor: compares every handshake against the head of the expected-sample queue.
    always @(negedge clk) begin
        if (!rst) begin
            check("sample_valid", 32'(sample_valid), 32'(exp_q.size() != 0));
            if (sample_valid && sample_ready && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sample_data", 32'(sample_data), 32'(mon_e.data));
                check("sample_index", 32'(sample_index), 32'(mon_e.index));
                check("sample_last", 32'(sample_last), 32'(mon_e.last));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            trigger_in  = 1'b0;
            waveform_in = 1'($urandom_range(0, 1));
            drive_ready();
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
    endtask

    // One burst; k counts cycles after the edge that accepts the rise. abort_k applies rst, retrig_k re-raises trigger.
    task automatic run_burst(input int dur, input int abort_k, input int retrig_k);
        int   k_done;
        int   sum;
        int   ph;
        int   j;
        int   n;
        bit   pend;
        bit   b;
        exp_t pend_e;
        int   pdata[$];
        k_done = (dur == 0) ? 0 : A + dur * P;
        sum    = 0;
        pend   = 1'b0;
        @(posedge clk); #1;
        trigger_in  = 1'b1;
        duration_in = IW'(dur);
        drive_ready();
        @(posedge clk);
        for (int k = 0; k <= k_done; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (k == 0) begin
                exp_overflow = 1'b0;
                exp_shape    = 1'b0;
            end
            if (pend) begin
                pend = 1'b0;
                pdata.push_back(pend_e.data);
                n = pdata.size();
                if (n > 1) begin
                    if ((n - 2) < dur / 2) begin
                        if (pdata[n-1] < pdata[n-2]) exp_shape = 1'b1;
                    end else begin
                        if (pdata[n-1] > pdata[n-2]) exp_shape = 1'b1;
                    end
                end
                if (exp_q.size() >= DEPTH) exp_overflow = 1'b1;
                else                       exp_q.push_back(pend_e);
            end
            if (k == abort_k) begin
                rst         = 1'b1;
                trigger_in  = 1'b0;
                waveform_in = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                exp_overflow = 1'b0;
                exp_shape    = 1'b0;
                drive_ready();
                @(negedge clk);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_overflow", 32'(overflow), 32'd0);
                idle(3);
                return;
            end
            trigger_in  = (k == retrig_k);
            duration_in = (k == retrig_k) ? IW'(3) : IW'($urandom_range(0, 255));
            drive_ready();
            if (k >= A && k < k_done) begin
                ph  = (k - A) % P;
                j   = (k - A) / P;
                b   = random_bits ? 1'($urandom_range(0, 1)) : (ph < duties[j]);
                waveform_in = b;
                sum += int'(b);
                if (ph == P - 1) begin
                    pend   = 1'b1;
                    pend_e = '{data: sum, index: j, last: (j == dur - 1)};
                    sum    = 0;
                end
            end else begin
                waveform_in = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("busy", 32'(busy), 32'(k < k_done));
            check("done", 32'(done), 32'(k == k_done));
            check("overflow", 32'(overflow), 32'(exp_overflow));
            check("shape_err", 32'(shape_err), 32'(SHAPE_ON && exp_shape));
        end
        @(posedge clk); #1;
        trigger_in = 1'b0;
        drive_ready();
        @(negedge clk);
        check("post_busy", 32'(busy), 32'd0);
        check("post_done", 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        trigger_in   = 1'b0;
        duration_in  = '0;
        waveform_in  = 1'b0;
        sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_data", 32'(sample_data), 32'd0);
        check("rst_index", 32'(sample_index), 32'd0);
        check("rst_last", 32'(sample_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_shape", 32'(shape_err), 32'd0);

        // Fixed 5/16 duty, always ready.
        ready_mode = 0;
        for (int i = 0; i < 4; i++) duties[i] = 5;
        run_burst(4, -1, -1);
        idle(4);

        // Constant high then constant low.
        duties[0] = 16; duties[1] = 16;
        run_burst(2, -1, -1);
        duties[0] = 0; duties[1] = 0;
        run_burst(2, -1, -1);
        idle(3);

        // Consumer stalled: four samples held, the rest dropped, then drained in order.
        ready_mode = 1;
        for (int i = 0; i < 6; i++) duties[i] = $urandom_range(0, P);
        run_burst(6, -1, -1);
        check("overflow_sticky", 32'(overflow), 32'd1);
        ready_mode = 0;
        idle(8);

        // Zero-length burst, re-trigger while busy, and re-trigger in the done cycle.
        run_burst(0, -1, -1);
        idle(2);
        for (int i = 0; i < 2; i++) duties[i] = $urandom_range(0, P);
        run_burst(2, -1, 10);
        run_burst(1, -1, A + P);
        idle(3);

        // Reset in the middle of period 2, then a fresh burst restarts at index 0.
        ready_mode = 2;
        for (int i = 0; i < 8; i++) duties[i] = $urandom_range(0, P);
        run_burst(8, A + 2 * P + 5, -1);
        run_burst(2, -1, -1);
        ready_mode = 0;
        idle(6);

        // Triangle shape, then a dip after the first rise.
        duties[0] = 0; duties[1] = 8; duties[2] = 16; duties[3] = 8;
        run_burst(4, -1, -1);
        duties[0] = 0; duties[1] = 8; duties[2] = 4; duties[3] = 8;
        run_burst(4, -1, -1);
        idle(4);

        // Randomized bursts with random backpressure.
        repeat (8) begin
            ready_mode  = $urandom_range(0, 2);
            random_bits = 1'($urandom_range(0, 1));
            for (int i = 0; i < 6; i++) duties[i] = $urandom_range(0, P);
            run_burst($urandom_range(0, 6), -1, -1);
            idle(2);
        end
        ready_mode = 0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
